// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator: pattern encodings,
// default raster size and the colour-bar palette.
package tpg_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Video bus between the VGA timing stage and the pattern generator:
// raster position/sync in, aligned colour and delayed sync out.
interface test_pattern_gen_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       blank;
  logic       hsync;
  logic       vsync;
  logic [7:0] pixel_r;
  logic [7:0] pixel_g;
  logic [7:0] pixel_b;
  logic       hsync_d;
  logic       vsync_d;
  logic       blank_d;

  modport master (
    output pixel_x, pixel_y, blank, hsync, vsync,
    input  pixel_r, pixel_g, pixel_b, hsync_d, vsync_d, blank_d
  );

  modport slave (
    input  pixel_x, pixel_y, blank, hsync, vsync,
    output pixel_r, pixel_g, pixel_b, hsync_d, vsync_d, blank_d
  );
endinterface

// File: rtl/tpg_frame_ctrl.sv
// Per-frame control: vsync falling-edge detector, frame counter, pending and
// displayed pattern mode, and horizontal scroll offset.
module tpg_frame_ctrl
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int SCROLL_STEP = 1
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       vsync,
  input  logic [1:0] mode_sel,
  input  logic       mode_req,
  input  logic       scroll_en,
  output logic [7:0] frame_cnt,
  output mode_e      mode_cur,
  output logic [9:0] scroll_off
);

  logic        vsync_q;
  logic        armed;
  logic        frame_start;
  mode_e       mode_pend;
  logic [10:0] scroll_sum;
  logic [9:0]  scroll_next;

  // armed masks the first cycle after reset, when vsync_q still holds its
  // reset value of 1 and a low vsync would otherwise look like an edge.
  assign frame_start = armed & vsync_q & ~vsync;

  always_comb begin
    scroll_sum  = {1'b0, scroll_off} + 11'(SCROLL_STEP);
    scroll_next = (scroll_sum >= 11'(H_ACTIVE)) ? 10'(scroll_sum - 11'(H_ACTIVE))
                                                : scroll_sum[9:0];
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      vsync_q    <= 1'b1;
      armed      <= 1'b0;
      frame_cnt  <= 8'd0;
      mode_pend  <= MODE_BARS;
      mode_cur   <= MODE_BARS;
      scroll_off <= 10'd0;
    end else begin
      vsync_q <= vsync;
      armed   <= 1'b1;
      if (mode_req) mode_pend <= mode_e'(mode_sel);
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_cur  <= mode_pend;
        if (scroll_en) scroll_off <= scroll_next;
      end
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// VGA test pattern generator: two-stage pixel pipeline (scroll/bounds, then
// colour) driven by per-frame mode and scroll state from tpg_frame_ctrl.
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SCROLL_STEP = 1
) (
  input  logic                     clk_25mhz,
  input  logic                     rst,
  test_pattern_gen_if.slave        vid,
  input  logic [1:0]               mode_sel,
  input  logic                     mode_req,
  input  logic                     scroll_en,
  output logic [7:0]               frame_cnt,
  output logic [1:0]               mode_cur
);

  localparam int BAR_W = H_ACTIVE / 8;

  mode_e       mode_cur_e;
  logic [9:0]  scroll_off;

  logic [10:0] x_sum;
  logic [9:0]  x_eff;
  logic        oob;

  logic [9:0]  x_eff_p1;
  logic [8:0]  y_p1;
  mode_e       mode_p1;
  logic [7:0]  fcnt_p1;
  logic        vld_p1, blank_p1, hsync_p1, vsync_p1, oob_p1;

  logic [9:0]  bar_q;
  logic [2:0]  bar_idx;
  logic [23:0] colour;

  logic [23:0] rgb_p2;
  logic        hsync_p2, vsync_p2, blank_p2;

  tpg_frame_ctrl #(
    .H_ACTIVE    (H_ACTIVE),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_frame_ctrl (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .vsync      (vid.vsync),
    .mode_sel   (mode_sel),
    .mode_req   (mode_req),
    .scroll_en  (scroll_en),
    .frame_cnt  (frame_cnt),
    .mode_cur   (mode_cur_e),
    .scroll_off (scroll_off)
  );

  assign mode_cur = mode_cur_e;

  always_comb begin
    x_sum = {1'b0, vid.pixel_x} + {1'b0, scroll_off};
    x_eff = (x_sum >= 11'(H_ACTIVE)) ? 10'(x_sum - 11'(H_ACTIVE)) : x_sum[9:0];
    oob   = ({1'b0, vid.pixel_x} >= 11'(H_ACTIVE)) ||
            ({1'b0, vid.pixel_y} >= 11'(V_ACTIVE));
  end

  // ---- stage 1: scrolled column, bounds flag, aligned sync/blank ----
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      blank_p1 <= 1'b1;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      oob_p1   <= 1'b0;
    end else begin
      vld_p1   <= 1'b1;
      blank_p1 <= vid.blank;
      hsync_p1 <= vid.hsync;
      vsync_p1 <= vid.vsync;
      oob_p1   <= oob;
    end
  end

  // Mode and frame count are captured with the pixel so a frame boundary
  // never splits one pixel's colour decision across two states.
  always_ff @(posedge clk_25mhz) begin
    x_eff_p1 <= x_eff;
    y_p1     <= vid.pixel_y[8:0];
    mode_p1  <= mode_cur_e;
    fcnt_p1  <= frame_cnt;
  end

  always_comb begin
    bar_q   = x_eff_p1 / 10'(BAR_W);
    bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
    colour  = 24'h000000;
    case (mode_p1)
      MODE_BARS:  colour = bar_colour(bar_idx);
      MODE_GRID:  colour = ((x_eff_p1[5:0] == 6'd0) || (y_p1[5:0] == 6'd0))
                           ? 24'hFFFFFF : 24'h000000;
      MODE_GRAD:  colour = {x_eff_p1[9:2], y_p1[8:1], fcnt_p1};
      MODE_CHECK: colour = (x_eff_p1[5] ^ y_p1[5]) ? 24'hFFFFFF : 24'h000000;
      default:    colour = 24'h000000;
    endcase
    if (!vld_p1 || blank_p1 || oob_p1) colour = 24'h000000;
  end

  // ---- stage 2: registered colour and delayed sync/blank ----
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      rgb_p2   <= 24'h000000;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
      blank_p2 <= 1'b1;
    end else begin
      rgb_p2   <= colour;
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
      blank_p2 <= blank_p1;
    end
  end

  assign vid.pixel_r = rgb_p2[23:16];
  assign vid.pixel_g = rgb_p2[15:8];
  assign vid.pixel_b = rgb_p2[7:0];
  assign vid.hsync_d = hsync_p2;
  assign vid.vsync_d = vsync_p2;
  assign vid.blank_d = blank_p2;

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter SCROLL_STEP, default 1: pixels added to the scroll offset per frame; legal range 1..H_ACTIVE-1.
REQ-004 clk_25mhz  in  1  pixel clock; all logic on its rising edge; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pixel_x  in  10  current column from the VGA timing stage.
REQ-007 pixel_y  in  10  current row from the VGA timing stage.
REQ-008 blank  in  1  high during horizontal or vertical blanking.
REQ-009 hsync  in  1  active-low horizontal sync.
REQ-010 vsync  in  1  active-low vertical sync.
REQ-011 mode_sel  in  2  requested pattern: 0 bars, 1 grid, 2 gradient, 3 checker.
REQ-012 mode_req  in  1  one-cycle strobe that captures mode_sel.
REQ-013 scroll_en  in  1  level; enables horizontal scroll.
REQ-014 pixel_r, pixel_g, pixel_b  out  8 each  registered colour.
REQ-015 hsync_d, vsync_d, blank_d  out  1 each  inputs delayed to align with the colour outputs.
REQ-016 frame_cnt  out  8  count of completed frame starts.
REQ-017 mode_cur  out  2  pattern currently displayed.

Function
REQ-018 Frame start SHALL be one cycle: the registered vsync is 1 and the current vsync is 0 (falling edge).
REQ-019 frame_cnt SHALL increment by 1 at each frame start and wrap from 255 to 0.
REQ-020 mode_req SHALL load mode_sel into mode_pend; the last strobe before a frame start wins.
REQ-021 mode_cur SHALL load mode_pend only at a frame start; a mode_req on the same cycle as a frame start takes effect at the next frame start.
REQ-022 When scroll_en=1, scroll_off SHALL add SCROLL_STEP at each frame start, modulo H_ACTIVE; when scroll_en=0, scroll_off holds.
REQ-023 Stage 1 SHALL register x_eff = pixel_x + scroll_off, minus H_ACTIVE if the sum >= H_ACTIVE; it also registers pixel_y, blank, the sync inputs and a flag oob = (pixel_x >= H_ACTIVE or pixel_y >= V_ACTIVE).
REQ-024 Stage 2 SHALL register the colour; input-to-output latency is exactly 2 cycles for colour, hsync_d, vsync_d and blank_d.
REQ-025 Mode 0, bars: 8 equal bars of H_ACTIVE/8 columns, indexed by x_eff; colours white, yellow, cyan, green, magenta, red, blue, black (each channel 0xFF or 0x00).
REQ-026 Mode 1, grid: white where x_eff[5:0]==0 or pixel_y[5:0]==0, else black.
REQ-027 Mode 2, gradient: r = x_eff[9:2], g = pixel_y[8:1], b = frame_cnt.
REQ-028 Mode 3, checker: white when x_eff[5] XOR pixel_y[5] is 1, else black.
REQ-029 If blank or oob is set in stage 1, the stage-2 colour SHALL be 0x000000 regardless of mode.
REQ-030 mode_cur, scroll_off and frame_cnt SHALL change only at a frame start, never mid-frame.

Reset
REQ-031 While rst=1, at every clock: pixel_r/g/b=0, hsync_d=1, vsync_d=1, blank_d=1, frame_cnt=0, mode_cur=0, mode_pend=0, scroll_off=0, vsync edge register=1, pipeline valid flags cleared.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge; the first colour after release appears 2 cycles after release.
REQ-033 No frame start SHALL be detected on the first cycle after reset release, even if vsync is low.

Structure
REQ-034 A shared package tpg_pkg SHALL hold the mode encoding constants, H_ACTIVE/V_ACTIVE defaults and the 8-entry bar colour table.
REQ-035 One sub-module, tpg_frame_ctrl, SHALL hold the vsync edge detector, frame_cnt, mode_pend/mode_cur and scroll_off; the parent holds the 2-stage pixel pipeline.

Verification
REQ-036 Mode 0, scroll off, pixel_x=0/80/639 in active area -> 2 cycles later RGB = FFFFFF / FFFF00 / 000000.
REQ-037 Scroll: scroll_en=1, SCROLL_STEP=1, after 3 frame starts pixel_x=637 -> x_eff=0; after 640 frame starts scroll_off=0.
REQ-038 Mode change: mode_req with mode_sel=1 mid-frame -> mode_cur stays 0 until the vsync falling edge, then becomes 1; the same strobe coincident with the edge -> change deferred one frame.
REQ-039 Blanking: blank=1 or pixel_x=700 in mode 2 -> RGB 000000; blank_d, hsync_d and vsync_d track the inputs with 2-cycle delay.
REQ-040 frame_cnt wrap and reset: 256 frame starts -> frame_cnt=0; rst pulsed mid-line -> all REQ-031 values on the next edge, no spurious frame start with vsync held low.
